// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared types, constants and helpers for the sequential AES key schedule.
// Mode decoding and the GF(2^8) doubling step live here.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'd0,
    MODE_192 = 2'd1,
    MODE_256 = 2'd2,
    MODE_BAD = 2'd3
  } key_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int MAX_NW = 60;

  function automatic logic [3:0] nk_of(input key_mode_e m);
    case (m)
      MODE_192: nk_of = 4'd6;
      MODE_256: nk_of = 4'd8;
      default:  nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_mode_e m);
    nr_of = nk_of(m) + 4'd6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_sbox.sv
// Combinational AES forward S-box; four copies form SubWord.
// The table is stored MSB-first, so entry k sits at bits [(255-k)*8 +: 8].
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always_comb begin
    y = SBOX[(11'd255 - {3'd0, a}) * 11'd8 +: 8];
  end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: loads the cipher key, derives one
// schedule word per cycle into a local store, and serves round keys by index.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4,
  parameter int MAX_NK  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [1:0]                       key_mode,
  input  logic [MAX_NK-1:0][regSize-1:0]   key_in,
  output logic                             busy,
  output logic                             done,
  output logic                             keys_valid,
  output logic [3:0]                       num_rounds,
  input  logic [3:0]                       rd_round,
  output logic [vecSize-1:0][regSize-1:0]  rd_key
);

  state_e            state, state_next;
  logic [31:0]       w [0:MAX_NW-1];
  logic [3:0]        nk_q;
  logic [5:0]        idx;
  logic [2:0]        phase;
  logic [7:0]        rcon;
  logic [31:0]       prev, sub_in, sub_out, temp;
  logic [5:0]        last_idx;
  logic [5:0]        rd_base;
  logic              accept;

  assign accept   = start && (key_mode != 2'd3);
  assign last_idx = {num_rounds, 2'b11};
  assign rd_base  = {rd_round, 2'b00};

  // Word-wise S-box path: rotate only on the rcon step of each NK-word group.
  assign prev   = w[idx - 6'd1];
  assign sub_in = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
  end

  always_comb begin
    temp = prev;
    if (phase == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk_q == 4'd8 && phase == 3'd4)
      temp = sub_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = EXPAND;
      EXPAND:  if (idx == last_idx) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == EXPAND);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_NW; k++) w[k] <= '0;
      nk_q       <= 4'd4;
      idx        <= '0;
      phase      <= '0;
      rcon       <= 8'h01;
      keys_valid <= 1'b0;
      num_rounds <= '0;
      rd_key     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          nk_q       <= nk_of(key_mode_e'(key_mode));
          num_rounds <= nr_of(key_mode_e'(key_mode));
          keys_valid <= 1'b0;
        end
        LOAD: begin
          for (int k = 0; k < MAX_NK; k++)
            if (k < int'(nk_q)) w[k] <= key_in[k];
          idx   <= {2'b00, nk_q};
          phase <= '0;
          rcon  <= 8'h01;
        end
        EXPAND: begin
          w[idx] <= w[idx - {2'b00, nk_q}] ^ temp;
          if (phase == 3'd0) rcon <= xtime(rcon);
          phase <= ({1'b0, phase} == nk_q - 4'd1) ? 3'd0 : phase + 3'd1;
          idx   <= idx + 6'd1;
        end
        default: keys_valid <= 1'b1;
      endcase
      // Indices past the last round of the active mode read as zero.
      for (int j = 0; j < vecSize; j++)
        rd_key[j] <= (rd_round <= num_rounds) ? w[rd_base + 6'(j)] : '0;
    end
  end

endmodule
